// File: rtl/sysid_ctrl_pkg.sv
// Shared definitions for the sysid boot checker / access arbiter.
// Contents:
//   state_e          - controller FSM states
//   SYSID_DATA_W     - width of the sysid read data word
//   SYSID_ADDR_ID/TS - word addresses of the ID and build-timestamp registers
//   SYSID_*_DEFAULT  - default expected values for the two words
package sysid_ctrl_pkg;

    localparam int unsigned SYSID_DATA_W = 32;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [SYSID_DATA_W-1:0] SYSID_ID_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [SYSID_DATA_W-1:0] SYSID_TS_DEFAULT = 32'h5B91_FC55;

    typedef enum logic [3:0] {
        StSettle,
        StSetId,
        StCapId,
        StSetTs,
        StCapTs,
        StEval,
        StIdle,
        StCpuSet,
        StCpuCap
    } state_e;

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// Bus bundle around the sysid checker: the sysid slave read port and the
// CPU-side request/ack port.
// Signals:
//   sid_address  - word address presented to sysid (driven by the controller)
//   sid_readdata - sysid read data, combinational from sid_address
//   cpu_req      - CPU read request, held until cpu_ack
//   cpu_addr     - CPU word select
//   cpu_ack      - one-cycle completion pulse
//   cpu_rdata    - data returned to the CPU, valid with cpu_ack
// Modports: master = controller side, slave = sysid model + CPU requester side.
interface sysid_check_ctrl_if;
    import sysid_ctrl_pkg::*;

    logic                    sid_address;
    logic [SYSID_DATA_W-1:0] sid_readdata;
    logic                    cpu_req;
    logic                    cpu_addr;
    logic                    cpu_ack;
    logic [SYSID_DATA_W-1:0] cpu_rdata;

    modport master (
        output sid_address,
        input  sid_readdata,
        input  cpu_req,
        input  cpu_addr,
        output cpu_ack,
        output cpu_rdata
    );

    modport slave (
        input  sid_address,
        output sid_readdata,
        output cpu_req,
        output cpu_addr,
        input  cpu_ack,
        input  cpu_rdata
    );

endinterface

// File: rtl/sysid_check_ctrl.sv
// Boot-time sequencer and access arbiter for the sysid slave. After reset it
// reads the ID and timestamp words, compares them with EXP_ID/EXP_TS, retries
// up to RETRY_MAX extra passes on mismatch, then shares the sysid read port
// with a single CPU requester.
// Ports:
//   clock, reset     - rising-edge clock, asynchronous active-high reset
//   bus (master)     - sysid read port and CPU request/ack port
//   recheck          - single-cycle pulse, starts a new check (IDLE only)
//   busy             - high in every state except IDLE
//   done, fail       - last check finished / exhausted its retries
//   id_ok, ts_ok     - per-word result of the most recent evaluation
//   id_word, ts_word - most recently captured ID and timestamp words
module sysid_check_ctrl
    import sysid_ctrl_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXP_ID    = SYSID_ID_DEFAULT,
    parameter logic [SYSID_DATA_W-1:0] EXP_TS    = SYSID_TS_DEFAULT,
    parameter int unsigned             SETTLE    = 4,
    parameter int unsigned             RETRY_MAX = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    sysid_check_ctrl_if.master       bus,
    input  logic                     recheck,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic                     id_ok,
    output logic                     ts_ok,
    output logic [SYSID_DATA_W-1:0]  id_word,
    output logic [SYSID_DATA_W-1:0]  ts_word
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    // A zero-retry build still needs a 1-bit counter to stay legal.
    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    state_e         state;
    logic [SW-1:0]  settle_cnt;
    logic [RW-1:0]  retry_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= StSettle;
            settle_cnt      <= SW'(SETTLE);
            retry_cnt       <= '0;
            bus.sid_address <= SYSID_ADDR_ID;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_rdata   <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            fail            <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            id_word         <= '0;
            ts_word         <= '0;
        end else begin
            bus.cpu_ack <= 1'b0;
            unique case (state)
                StSettle: begin
                    if (settle_cnt <= SW'(1)) begin
                        state <= StSetId;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                StSetId: begin
                    bus.sid_address <= SYSID_ADDR_ID;
                    state           <= StCapId;
                end
                StCapId: begin
                    id_word <= bus.sid_readdata;
                    state   <= StSetTs;
                end
                StSetTs: begin
                    bus.sid_address <= SYSID_ADDR_TS;
                    state           <= StCapTs;
                end
                StCapTs: begin
                    ts_word <= bus.sid_readdata;
                    state   <= StEval;
                end
                StEval: begin
                    id_ok <= (id_word == EXP_ID);
                    ts_ok <= (ts_word == EXP_TS);
                    if ((id_word == EXP_ID) && (ts_word == EXP_TS)) begin
                        done  <= 1'b1;
                        fail  <= 1'b0;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else if (retry_cnt < RW'(RETRY_MAX)) begin
                        // Retries skip the settle delay.
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= StSetId;
                    end else begin
                        done  <= 1'b1;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    // recheck wins; a coincident cpu_req stays pending until after done.
                    if (recheck) begin
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        id_ok      <= 1'b0;
                        ts_ok      <= 1'b0;
                        settle_cnt <= SW'(SETTLE);
                        retry_cnt  <= '0;
                        busy       <= 1'b1;
                        state      <= StSettle;
                    end else if (bus.cpu_req) begin
                        busy  <= 1'b1;
                        state <= StCpuSet;
                    end
                end
                StCpuSet: begin
                    bus.sid_address <= bus.cpu_addr;
                    state           <= StCpuCap;
                end
                StCpuCap: begin
                    bus.cpu_rdata <= bus.sid_readdata;
                    bus.cpu_ack   <= 1'b1;
                    busy          <= 1'b0;
                    state         <= StIdle;
                end
                default: begin
                    settle_cnt <= SW'(SETTLE);
                    retry_cnt  <= '0;
                    busy       <= 1'b1;
                    state      <= StSettle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with default parameters. A behavioural
// sysid model answers reads; expected CPU read data is queued when a request
// is driven and popped when cpu_ack appears.
module tb_sysid_check_ctrl;
    import sysid_ctrl_pkg::*;

    localparam int BOUND = 200;

    logic        clock = 1'b0;
    logic        reset;
    logic        recheck;
    logic        busy, done, fail, id_ok, ts_ok;
    logic [31:0] id_word, ts_word;
    logic [31:0] model_id, model_ts;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    int rise_cnt = 0;
    logic prev_addr = 1'b0;
    logic [31:0] exp_q[$];

    sysid_check_ctrl_if bus ();

    assign bus.sid_readdata = (bus.sid_address == 1'b1) ? model_ts : model_id;

    sysid_check_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .recheck (recheck),
        .busy    (busy),
        .done    (done),
        .fail    (fail),
        .id_ok   (id_ok),
        .ts_ok   (ts_ok),
        .id_word (id_word),
        .ts_word (ts_word)
    );

    always #5 clock = ~clock;

    // Event monitors, sampled just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (bus.cpu_ack === 1'b1) ack_cnt++;
        if (bus.sid_address === 1'b1 && prev_addr === 1'b0) rise_cnt++;
        prev_addr = bus.sid_address;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (done !== 1'b1 && n < BOUND) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.cpu_ack !== 1'b1 && n < BOUND);
    endtask

    task automatic pop_rdata(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.cpu_rdata, e);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"},     {31'd0, busy},            32'd1);
        chk({pfx, "_done"},     {31'd0, done},            32'd0);
        chk({pfx, "_fail"},     {31'd0, fail},            32'd0);
        chk({pfx, "_id_ok"},    {31'd0, id_ok},           32'd0);
        chk({pfx, "_ts_ok"},    {31'd0, ts_ok},           32'd0);
        chk({pfx, "_id_word"},  id_word,                  32'd0);
        chk({pfx, "_ts_word"},  ts_word,                  32'd0);
        chk({pfx, "_cpu_ack"},  {31'd0, bus.cpu_ack},     32'd0);
        chk({pfx, "_cpu_rdata"}, bus.cpu_rdata,           32'd0);
        chk({pfx, "_sid_addr"}, {31'd0, bus.sid_address}, 32'd0);
    endtask

    initial begin
        int n;
        int ack_base;
        reset        = 1'b1;
        recheck      = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 1'b0;
        model_id     = 32'hDEAD_BEEF;
        model_ts     = 32'h5B91_FC55;

        // Reset state.
        repeat (3) @(negedge clock);
        chk_reset_vals("rst");

        // Boot check with a CPU request raised during boot (sampled at edge 2).
        reset = 1'b0;
        @(negedge clock);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 1'b0;
        exp_q.push_back(32'hDEAD_BEEF);
        wait_done(1, n);
        chk("boot_done_edge", n, 32'd9);
        chk("boot_id_ok", {31'd0, id_ok}, 32'd1);
        chk("boot_ts_ok", {31'd0, ts_ok}, 32'd1);
        chk("boot_fail", {31'd0, fail}, 32'd0);
        chk("boot_busy", {31'd0, busy}, 32'd0);
        chk("boot_id_word", id_word, 32'hDEAD_BEEF);
        chk("boot_ts_word", ts_word, 32'h5B91_FC55);
        chk("boot_no_early_ack", ack_cnt, 32'd0);
        wait_ack(n);
        chk("boot_ack_lat", n, 32'd3);
        pop_rdata("boot_rdata");

        // Back-to-back CPU read of the timestamp word.
        bus.cpu_addr = 1'b1;
        exp_q.push_back(32'h5B91_FC55);
        wait_ack(n);
        chk("b2b_ack_lat", n, 32'd3);
        pop_rdata("b2b_rdata");
        bus.cpu_req = 1'b0;
        @(negedge clock);
        chk("ack_one_cycle", {31'd0, bus.cpu_ack}, 32'd0);
        repeat (3) @(negedge clock);
        chk("rdata_hold", bus.cpu_rdata, 32'h5B91_FC55);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack_total", ack_cnt, 32'd2);

        // ID mismatch with recheck and cpu_req in the same IDLE cycle.
        model_id     = 32'hDEAD_BEEE;
        recheck      = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 1'b0;
        exp_q.push_back(32'hDEAD_BEEE);
        ack_base     = ack_cnt;
        rise_cnt     = 0;
        @(negedge clock);
        recheck = 1'b0;
        chk("recheck_clears_done", {31'd0, done}, 32'd0);
        chk("recheck_busy", {31'd0, busy}, 32'd1);
        chk("recheck_clears_ok", {30'd0, id_ok, ts_ok}, 32'd0);
        wait_done(1, n);
        chk("retry_done_edge", n, 32'd25);
        chk("retry_fail", {31'd0, fail}, 32'd1);
        chk("retry_id_ok", {31'd0, id_ok}, 32'd0);
        chk("retry_ts_ok", {31'd0, ts_ok}, 32'd1);
        chk("retry_id_word", id_word, 32'hDEAD_BEEE);
        chk("retry_pass_count", rise_cnt, 32'd4);
        chk("no_ack_during_check", ack_cnt - ack_base, 32'd0);
        wait_ack(n);
        chk("post_check_ack_lat", n, 32'd3);
        pop_rdata("post_check_rdata");
        bus.cpu_req = 1'b0;

        // Reset asserted while in CAP_TS.
        model_id = 32'hDEAD_BEEF;
        @(negedge clock);
        recheck = 1'b1;
        @(negedge clock);
        recheck = 1'b0;
        repeat (7) @(negedge clock);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        chk("pre_reset_sid_addr", {31'd0, bus.sid_address}, 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clock);
        reset = 1'b0;

        // Clean check after release; a recheck during SETTLE must be dropped.
        @(negedge clock);
        @(negedge clock);
        recheck = 1'b1;
        @(negedge clock);
        recheck = 1'b0;
        wait_done(3, n);
        chk("rst_done_edge", n, 32'd9);
        chk("rst_fail", {31'd0, fail}, 32'd0);
        chk("rst_id_ok", {31'd0, id_ok}, 32'd1);
        @(negedge clock);
        chk("recheck_not_queued_busy", {31'd0, busy}, 32'd0);
        chk("recheck_not_queued_done", {31'd0, done}, 32'd1);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
